dmem_responder: RTL and testbench

Memory-side responder for the hart's data-memory port, replacing the combinational dmem model with a latency-bearing, handshaked word memory. Accepts one aligned, byte-masked read or write request at a time, performs it against an internal word array, and returns a single-cycle response after a fixed latency. It is the responder end of the dmem address/ren/wen/wdata/mask protocol that the hart drives.

---
 rtl/dmem_responder.sv | 146 ++++++++++++++
 tb/tb_dmem_responder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - latency-bearing, handshaked, byte-masked word memory on the dmem port
// Accepts one request at a time and answers it with a one-cycle response after LATENCY cycles.
module dmem_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned LATENCY     = 2
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [31:0] i_req_addr,
   input  logic        i_req_ren,
   input  logic        i_req_wen,
   input  logic [31:0] i_req_wdata,
   input  logic [3:0]  i_req_mask,
   output logic        o_req_ready,
   output logic        o_rsp_valid,
   output logic [31:0] o_rsp_rdata,
   output logic        o_rsp_err
);

   localparam int unsigned AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [31:0] DEPTH_W  = 32'(DEPTH_WORDS);
   localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t        state;
   logic [3:0]    cnt;
   logic [31:0]   mem [DEPTH_WORDS];

   logic [AW-1:0] req_idx;
   logic          req_rd;
   logic          req_wr;
   logic          req_err;
   logic [31:0]   req_wdata;
   logic [3:0]    req_mask;

   logic [31:0]   off;
   logic          in_err;
   logic          acc;
   logic          go_resp;
   logic [AW-1:0] sel_idx;
   logic          sel_rd;
   logic          sel_wr;
   logic          sel_err;
   logic [31:0]   sel_wdata;
   logic [3:0]    sel_mask;
   logic [31:0]   sel_bmask;

   assign o_req_ready = (state != WAIT);
   assign acc         = o_req_ready & (i_req_ren | i_req_wen);

   // Addresses below BASE_ADDR wrap to huge offsets and so fail the range test.
   assign off    = i_req_addr - BASE_ADDR;
   assign in_err = (i_req_ren & i_req_wen) | (off[1:0] != 2'b00) |
                   (i_req_mask == 4'b0000) | ({2'b00, off[31:2]} >= DEPTH_W);

   // With LATENCY=1 the edge that accepts a request is also the edge that performs it.
   always_comb begin
      go_resp   = 1'b0;
      sel_idx   = req_idx;
      sel_rd    = req_rd;
      sel_wr    = req_wr;
      sel_err   = req_err;
      sel_wdata = req_wdata;
      sel_mask  = req_mask;
      if (LATENCY == 1) begin
         go_resp   = acc;
         sel_idx   = off[AW+1:2];
         sel_rd    = i_req_ren & ~in_err;
         sel_wr    = i_req_wen & ~in_err;
         sel_err   = in_err;
         sel_wdata = i_req_wdata;
         sel_mask  = i_req_mask;
      end else begin
         go_resp = (state == WAIT) && (cnt == 4'd1);
      end
   end

   assign sel_bmask = {{8{sel_mask[3]}}, {8{sel_mask[2]}}, {8{sel_mask[1]}}, {8{sel_mask[0]}}};

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= IDLE;
         cnt         <= 4'd0;
         req_idx     <= '0;
         req_rd      <= 1'b0;
         req_wr      <= 1'b0;
         req_err     <= 1'b0;
         req_wdata   <= 32'd0;
         req_mask    <= 4'd0;
         o_rsp_valid <= 1'b0;
         o_rsp_rdata <= 32'd0;
         o_rsp_err   <= 1'b0;
      end else begin
         o_rsp_valid <= go_resp;
         if (go_resp) begin
            o_rsp_err   <= sel_err;
            o_rsp_rdata <= sel_rd ? (mem[sel_idx] & sel_bmask) : 32'd0;
         end else begin
            o_rsp_err   <= 1'b0;
            o_rsp_rdata <= 32'd0;
         end

         case (state)
            IDLE, RESP: begin
               if (acc) begin
                  req_idx   <= off[AW+1:2];
                  req_rd    <= i_req_ren & ~in_err;
                  req_wr    <= i_req_wen & ~in_err;
                  req_err   <= in_err;
                  req_wdata <= i_req_wdata;
                  req_mask  <= i_req_mask;
                  if (LATENCY == 1) begin
                     state <= RESP;
                  end else begin
                     state <= WAIT;
                     cnt   <= CNT_LOAD;
                  end
               end else begin
                  state <= IDLE;
               end
            end
            WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  state <= RESP;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Word array is deliberately unreset; only masked lanes of a legal write change.
   always_ff @(posedge i_clk) begin
      if (go_resp && sel_wr) begin
         for (int b = 0; b < 4; b++) begin
            if (sel_mask[b]) begin
               mem[sel_idx][8*b +: 8] <= sel_wdata[8*b +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder at LATENCY=2 and LATENCY=1
module tb_dmem_responder;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          due;
   } exp_t;

   logic        clk;
   logic        rst_n     [2];
   logic [31:0] req_addr  [2];
   logic        req_ren   [2];
   logic        req_wen   [2];
   logic [31:0] req_wdata [2];
   logic [3:0]  req_mask  [2];
   logic        req_ready [2];
   logic        rsp_valid [2];
   logic [31:0] rsp_rdata [2];
   logic        rsp_err   [2];

   exp_t qa[$];
   exp_t qb[$];
   int   cyc   = 0;
   int   total = 0;
   int   bad   = 0;

   dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(2)) u_dut_l2 (
      .i_clk(clk), .i_rst_n(rst_n[0]), .i_req_addr(req_addr[0]), .i_req_ren(req_ren[0]),
      .i_req_wen(req_wen[0]), .i_req_wdata(req_wdata[0]), .i_req_mask(req_mask[0]),
      .o_req_ready(req_ready[0]), .o_rsp_valid(rsp_valid[0]), .o_rsp_rdata(rsp_rdata[0]),
      .o_rsp_err(rsp_err[0])
   );

   dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(1)) u_dut_l1 (
      .i_clk(clk), .i_rst_n(rst_n[1]), .i_req_addr(req_addr[1]), .i_req_ren(req_ren[1]),
      .i_req_wen(req_wen[1]), .i_req_wdata(req_wdata[1]), .i_req_mask(req_mask[1]),
      .o_req_ready(req_ready[1]), .o_rsp_valid(rsp_valid[1]), .o_rsp_rdata(rsp_rdata[1]),
      .o_rsp_err(rsp_err[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Response monitor: pops the scoreboard whenever a DUT presents a response.
   exp_t e;
   bit   got;
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (rsp_valid[d] === 1'b1) begin
            got = 0;
            if (d == 0 && qa.size() > 0) begin e = qa.pop_front(); got = 1; end
            if (d == 1 && qb.size() > 0) begin e = qb.pop_front(); got = 1; end
            if (!got) begin
               chk($sformatf("unexpected_rsp[%0d]", d), 32'd1, 32'd0);
            end else begin
               chk($sformatf("rsp_cycle[%0d]", d), 32'(cyc), 32'(e.due));
               chk($sformatf("rsp_rdata[%0d]", d), rsp_rdata[d], e.rdata);
               chk($sformatf("rsp_err[%0d]", d), {31'd0, rsp_err[d]}, {31'd0, e.err});
            end
         end
      end
   end

   // Called #1 after a rising edge; returns the cycle in which the request was accepted.
   task automatic issue(input int d, input logic ren, input logic wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] mask,
                        input logic [31:0] exp_rd, input logic exp_err, output int acc);
      exp_t x;
      int   lat;
      lat          = (d == 0) ? 2 : 1;
      req_addr[d]  = addr;
      req_ren[d]   = ren;
      req_wen[d]   = wen;
      req_wdata[d] = wdata;
      req_mask[d]  = mask;
      acc          = -1;
      for (int i = 0; i < 20 && acc < 0; i++) begin
         if (req_ready[d] === 1'b1) begin
            acc     = cyc;
            x.rdata = exp_rd;
            x.err   = exp_err;
            x.due   = cyc + lat;
            if (d == 0) qa.push_back(x);
            else        qb.push_back(x);
         end
         @(posedge clk);
         #1;
      end
      if (acc < 0) chk($sformatf("accept_timeout[%0d]", d), 32'd1, 32'd0);
      req_ren[d] = 1'b0;
      req_wen[d] = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int a0, a1;
      int acc_s [5];
      for (int d = 0; d < 2; d++) begin
         rst_n[d] = 1'b0; req_addr[d] = 0; req_ren[d] = 0; req_wen[d] = 0;
         req_wdata[d] = 0; req_mask[d] = 0;
      end
      idle(3);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("reset_ready[%0d]", d), {31'd0, req_ready[d]}, 32'd1);
         chk($sformatf("reset_valid[%0d]", d), {31'd0, rsp_valid[d]}, 32'd0);
         chk($sformatf("reset_rdata[%0d]", d), rsp_rdata[d], 32'd0);
         chk($sformatf("reset_err[%0d]", d), {31'd0, rsp_err[d]}, 32'd0);
      end
      rst_n[0] = 1'b1;
      rst_n[1] = 1'b1;
      idle(1);

      // LATENCY=2: full-word write/read, byte write and partial read
      issue(0, 0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 0, a0);
      idle(3);
      issue(0, 1, 0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 0, a0);
      idle(3);
      issue(0, 0, 1, 32'h20, 32'h11223344, 4'hF, 32'h0, 0, a0);
      issue(0, 0, 1, 32'h20, 32'hAA000000, 4'h8, 32'h0, 0, a0);
      issue(0, 1, 0, 32'h20, 32'h0, 4'hC, 32'hAA220000, 0, a0);
      issue(0, 1, 0, 32'h20, 32'h0, 4'h3, 32'h00003344, 0, a0);

      // back-to-back: read accepted in the write's RESP cycle sees the new data
      idle(3);
      issue(0, 0, 1, 32'h30, 32'h12345678, 4'hF, 32'h0, 0, a0);
      issue(0, 1, 0, 32'h30, 32'h0, 4'hF, 32'h12345678, 0, a1);
      chk("b2b_accept_gap", 32'(a1 - a0), 32'd2);

      // error cases, each followed by a read proving memory is untouched
      issue(0, 0, 1, 32'h0, 32'hCAFEF00D, 4'hF, 32'h0, 0, a0);
      issue(0, 1, 1, 32'h10, 32'h0, 4'hF, 32'h0, 1, a0);
      issue(0, 1, 0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 0, a0);
      issue(0, 0, 1, 32'h13, 32'h0, 4'hF, 32'h0, 1, a0);
      issue(0, 1, 0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 0, a0);
      issue(0, 0, 1, 32'h10, 32'h0, 4'h0, 32'h0, 1, a0);
      issue(0, 1, 0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 0, a0);
      issue(0, 0, 1, 32'h1000, 32'h0, 4'hF, 32'h0, 1, a0);
      issue(0, 1, 0, 32'h1000, 32'h0, 4'hF, 32'h0, 1, a0);
      issue(0, 1, 0, 32'h0, 32'h0, 4'hF, 32'hCAFEF00D, 0, a0);

      // reset during WAIT discards the pending write
      issue(0, 0, 1, 32'h40, 32'h5555AAAA, 4'hF, 32'h0, 0, a0);
      issue(0, 1, 0, 32'h40, 32'h0, 4'hF, 32'h5555AAAA, 0, a0);
      idle(4);
      req_addr[0] = 32'h40; req_wdata[0] = 32'h0; req_mask[0] = 4'hF; req_wen[0] = 1'b1;
      @(posedge clk);
      #1;
      req_wen[0] = 1'b0;
      chk("mid_op_ready_in_wait", {31'd0, req_ready[0]}, 32'd0);
      #2;
      rst_n[0] = 1'b0;
      #1;
      chk("async_rst_ready", {31'd0, req_ready[0]}, 32'd1);
      chk("async_rst_valid", {31'd0, rsp_valid[0]}, 32'd0);
      chk("async_rst_rdata", rsp_rdata[0], 32'd0);
      chk("async_rst_err", {31'd0, rsp_err[0]}, 32'd0);
      idle(2);
      rst_n[0] = 1'b1;
      idle(1);
      issue(0, 1, 0, 32'h40, 32'h0, 4'hF, 32'h5555AAAA, 0, a0);
      idle(4);

      // LATENCY=1: single read latency, then a stream accepted every cycle
      issue(1, 0, 1, 32'h0, 32'h01020304, 4'hF, 32'h0, 0, a0);
      idle(2);
      issue(1, 1, 0, 32'h0, 32'h0, 4'hF, 32'h01020304, 0, a0);
      idle(2);
      issue(1, 0, 1, 32'h4, 32'hA0B0C0D0, 4'hF, 32'h0, 0, acc_s[0]);
      issue(1, 1, 0, 32'h4, 32'h0, 4'h1, 32'h000000D0, 0, acc_s[1]);
      issue(1, 0, 1, 32'h0, 32'hEE000000, 4'h8, 32'h0, 0, acc_s[2]);
      issue(1, 1, 0, 32'h0, 32'h0, 4'hF, 32'hEE020304, 0, acc_s[3]);
      issue(1, 1, 0, 32'h8, 32'h0, 4'h0, 32'h0, 1, acc_s[4]);
      for (int i = 1; i < 5; i++) begin
         chk($sformatf("stream_accept_gap_%0d", i), 32'(acc_s[i] - acc_s[0]), 32'(i));
      end
      idle(4);

      chk("pending_rsp_l2", 32'(qa.size()), 32'd0);
      chk("pending_rsp_l1", 32'(qb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
